// File: rtl/ex_result_stage_pkg.sv
// rtl/ex_result_stage_pkg.sv - opcode constants and flag-class mapping for the execute result stage
package ex_result_stage_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    typedef enum logic [1:0] {
        FLAGS_NONE = 2'd0,
        FLAGS_Z    = 2'd1,
        FLAGS_ZVN  = 2'd2
    } flag_class_t;

    function automatic flag_class_t flag_class(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB:                 return FLAGS_ZVN;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: return FLAGS_Z;
            default:                        return FLAGS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ex_result_stage_if.sv
// rtl/ex_result_stage_if.sv - execute-to-memory result handshake and flag outputs
interface ex_result_stage_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_opcode;
    logic [DW-1:0] in_result;
    logic          in_ovfl;
    logic [RW-1:0] in_rd;
    logic          in_wr_en;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_rd;
    logic          out_wr_en;
    logic          flag_z;
    logic          flag_v;
    logic          flag_n;

    modport master (
        output flush, in_valid, in_opcode, in_result, in_ovfl, in_rd, in_wr_en, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wr_en, flag_z, flag_v, flag_n
    );

    modport slave (
        input  flush, in_valid, in_opcode, in_result, in_ovfl, in_rd, in_wr_en, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wr_en, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/ex_result_fifo.sv
// rtl/ex_result_fifo.sv - generic synchronous FIFO with push/pop/flush and occupancy count
module ex_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 21,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // DEPTH is a power of two, so natural pointer overflow gives modulo-DEPTH wrap
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign count    = cnt;

endmodule

// File: rtl/ex_result_stage.sv
// rtl/ex_result_stage.sv - buffers execute results in order and owns the Z/V/N flag register
module ex_result_stage
    import ex_result_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 16,
    parameter int RW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    ex_result_stage_if.slave bus
);
    localparam int W  = DW + RW + 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] count;
    logic [W-1:0]  head;
    logic          out_valid;
    logic          accept;
    logic          pop;
    logic          flag_z_q;
    logic          flag_v_q;
    logic          flag_n_q;
    flag_class_t   fclass;

    // in_ready looks only at registered occupancy so ALU timing never sees out_ready
    assign bus.in_ready = (count < CW'(DEPTH));
    assign out_valid    = (count != '0);
    assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop          = out_valid & bus.out_ready & ~bus.flush;

    ex_result_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .push      (accept),
        .push_data ({bus.in_wr_en, bus.in_rd, bus.in_result}),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    assign bus.out_valid  = out_valid;
    assign bus.out_result = out_valid ? head[DW-1:0] : '0;
    assign bus.out_rd     = out_valid ? head[DW+RW-1:DW] : '0;
    assign bus.out_wr_en  = out_valid & head[DW+RW];

    assign fclass = flag_class(bus.in_opcode);

    // Flags follow the accept, not the pop, so they are architecturally ahead of the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if (accept) begin
            case (fclass)
                FLAGS_ZVN: begin
                    flag_z_q <= (bus.in_result == '0);
                    flag_v_q <= bus.in_ovfl;
                    flag_n_q <= bus.in_result[DW-1];
                end
                FLAGS_Z: flag_z_q <= (bus.in_result == '0);
                default: ;
            endcase
        end
    end

    assign bus.flag_z = flag_z_q;
    assign bus.flag_v = flag_v_q;
    assign bus.flag_n = flag_n_q;

endmodule
